// File: rtl/fft16_r4_stream_if.sv
// Stream bundle for fft16_r4_stream: one sample port in, one bin port out.
// Handshake: a beat transfers on any rising clk edge where valid && ready are
// both high; a source holding valid keeps its payload stable until the beat
// transfers, and ready may change freely without waiting on valid.
interface fft16_r4_stream_if #(
    parameter int DW = 16,
    parameter int OW = DW + 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
    logic                 out_last;

    // Sample source / bin sink side
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );

    // FFT core side
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/fft16_r4_stream.sv
// Streaming 16-point radix-4 DIF FFT. Loads 16 samples, runs two in-place
// radix-4 stages (one butterfly per cycle), then unloads bins in natural order.
// Optional build macro FFT16_STAGE_SCALE_EN: divide each stage result by 4
// (round-half-up) so the output is X[k]/16; otherwise full-precision X[k].
module fft16_r4_stream #(
    parameter  int DW = 16,
    parameter  int TW = 16,
    localparam int OW = DW + 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fft16_r4_stream_if.slave        s,
    output logic [1:0]              state_dbg
);
    localparam int PW = OW + TW + 1;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (TW - 3);

    localparam real C1 = 0.9238795325112867;
    localparam real C2 = 0.7071067811865476;
    localparam real C3 = 0.3826834323650898;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STAGE1 = 2'd1,
        STAGE2 = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    // cos(2*pi*m/16), used for both the real part and (shifted) the sine
    function automatic real cos16(int m);
        case (m % 16)
            0:       return 1.0;
            1:       return C1;
            2:       return C2;
            3:       return C3;
            4:       return 0.0;
            5:       return -C3;
            6:       return -C2;
            7:       return -C1;
            8:       return -1.0;
            9:       return -C1;
            10:      return -C2;
            11:      return -C3;
            12:      return 0.0;
            13:      return C3;
            14:      return C2;
            15:      return C1;
            default: return 0.0;
        endcase
    endfunction

    // W16^m for m = 0..9 in Q2.(TW-2), rounded to nearest; im part is -sin
    function automatic logic [10*TW-1:0] build_rom(bit want_im);
        logic [10*TW-1:0] rom;
        real v;
        real sc;
        int  q;
        rom = '0;
        sc  = 2.0 ** (TW - 2);
        for (int m = 0; m < 10; m++) begin
            v = want_im ? -cos16(m + 12) : cos16(m);
            if (v >= 0.0) q = $rtoi(v * sc + 0.5);
            else          q = -$rtoi(-v * sc + 0.5);
            rom[m*TW +: TW] = TW'(q);
        end
        return rom;
    endfunction

    localparam logic [10*TW-1:0] ROM_RE = build_rom(1'b0);
    localparam logic [10*TW-1:0] ROM_IM = build_rom(1'b1);

    // Complex multiply by W16^e; e=0 and e=4 (x1, x-j) are exact bypasses
    function automatic logic [2*OW-1:0] twiddle(
        input logic signed [OW-1:0] ur,
        input logic signed [OW-1:0] ui,
        input logic [3:0]           e
    );
        logic signed [TW-1:0] wr;
        logic signed [TW-1:0] wi;
        logic signed [PW-1:0] pr;
        logic signed [PW-1:0] pi;
        logic signed [OW-1:0] zr;
        logic signed [OW-1:0] zi;
        wr = ROM_RE[int'(e)*TW +: TW];
        wi = ROM_IM[int'(e)*TW +: TW];
        pr = '0;
        pi = '0;
        if (e == 4'd0) begin
            zr = ur;
            zi = ui;
        end else if (e == 4'd4) begin
            zr = ui;
            zi = -ur;
        end else begin
            pr = PW'(ur) * PW'(wr) - PW'(ui) * PW'(wi) + HALF;
            pi = PW'(ur) * PW'(wi) + PW'(ui) * PW'(wr) + HALF;
            zr = OW'(pr >>> (TW - 2));
            zi = OW'(pi >>> (TW - 2));
        end
        return {zr, zi};
    endfunction

    // Per-stage output scaling
    function automatic logic signed [OW-1:0] stage_out(input logic signed [OW-1:0] v);
`ifdef FFT16_STAGE_SCALE_EN
        return (v + OW'(2)) >>> 2;
`else
        return v;
`endif
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic [3:0]           cnt_nxt;
    logic                 in_fire;
    logic                 out_fire;

    logic signed [OW-1:0] mem_re [16];
    logic signed [OW-1:0] mem_im [16];

    logic [3:0]           addr   [4];
    logic signed [OW-1:0] op_re  [4];
    logic signed [OW-1:0] op_im  [4];
    logic signed [OW-1:0] y_re   [4];
    logic signed [OW-1:0] y_im   [4];
    logic signed [OW-1:0] z_re   [4];
    logic signed [OW-1:0] z_im   [4];
    logic signed [OW-1:0] res_re [4];
    logic signed [OW-1:0] res_im [4];
    logic [3:0]           tw_exp [4];
    logic [3:0]           rd_addr;

    assign in_fire   = s.in_valid && s.in_ready;
    assign out_fire  = s.out_valid && s.out_ready;
    assign state_dbg = state;

    // State and counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= LOAD;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: count beats in LOAD/UNLOAD, butterflies in the two stages
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD: begin
                if (in_fire) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd15) state_nxt = STAGE1;
                end
            end
            STAGE1: begin
                cnt_nxt = (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
                if (cnt == 4'd3) state_nxt = STAGE2;
            end
            STAGE2: begin
                cnt_nxt = (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
                if (cnt == 4'd3) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                if (out_fire) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd15) state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: X[i] lives at digit-reversed location 4*(i%4) + i/4
    always_comb begin
        rd_addr     = {cnt[1:0], cnt[3:2]};
        s.in_ready  = (state == LOAD);
        s.out_valid = (state == UNLOAD);
        s.out_last  = (state == UNLOAD) && (cnt == 4'd15);
        s.out_re    = '0;
        s.out_im    = '0;
        if (state == UNLOAD) begin
            s.out_re = mem_re[rd_addr];
            s.out_im = mem_im[rd_addr];
        end
    end

    // Butterfly operand fetch and radix-4 kernel; writes go back to the same slots
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            if (state == STAGE2) addr[j] = {cnt[1:0], 2'(j)};
            else                 addr[j] = {2'(j), cnt[1:0]};
            op_re[j] = mem_re[addr[j]];
            op_im[j] = mem_im[addr[j]];
        end
        y_re[0] = op_re[0] + op_re[1] + op_re[2] + op_re[3];
        y_im[0] = op_im[0] + op_im[1] + op_im[2] + op_im[3];
        y_re[1] = op_re[0] + op_im[1] - op_re[2] - op_im[3];
        y_im[1] = op_im[0] - op_re[1] - op_im[2] + op_re[3];
        y_re[2] = op_re[0] - op_re[1] + op_re[2] - op_re[3];
        y_im[2] = op_im[0] - op_im[1] + op_im[2] - op_im[3];
        y_re[3] = op_re[0] - op_im[1] - op_re[2] + op_im[3];
        y_im[3] = op_im[0] + op_re[1] - op_im[2] - op_re[3];
    end

    // Twiddle W16^(n*k) after the first stage only, then optional scaling
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tw_exp[k] = (state == STAGE1) ? 4'(cnt[1:0]) * 4'(k) : 4'd0;
            {z_re[k], z_im[k]} = twiddle(y_re[k], y_im[k], tw_exp[k]);
            res_re[k] = stage_out(z_re[k]);
            res_im[k] = stage_out(z_im[k]);
        end
    end

    // Sample buffer: sign-extended loads, then in-place butterfly results
    always_ff @(posedge clk) begin
        if (state == LOAD && in_fire) begin
            mem_re[cnt] <= OW'(s.in_re);
            mem_im[cnt] <= OW'(s.in_im);
        end else if (state == STAGE1 || state == STAGE2) begin
            for (int j = 0; j < 4; j++) begin
                mem_re[addr[j]] <= res_re[j];
                mem_im[addr[j]] <= res_im[j];
            end
        end
    end
endmodule
